l2_line_responder: RTL and testbench
====================================

Name: l2_line_responder

Overview:
- Responder end of the L1 instruction-cache line-fill interface.
- Accepts a level-held line read request with a 26-bit line address.
- Fetches the 64-byte line as sixteen 32-bit beats from the external memory bus and assembles a 512-bit line.
- Returns the line with a one-cycle acknowledge pulse; a one-entry last-line buffer answers repeat requests without touching memory.

Parameters:
- LINE_ADDR_WIDTH, 26, width of the line address (byte address bits 31:6).
- ENABLE_LINE_BUFFER, 1, when 0 every request goes to memory and the buffer is never marked valid.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- l2_read_i  input  1  line request, held high by the requester until acknowledged.
- l2_addr_i  input  26  line address, stable while l2_read_i is high.
- l2_ack_o  output  1  one-cycle pulse: line on l2_data_o is valid this cycle.
- l2_data_o  output  512  assembled line; word at byte offset 4k occupies bits [511-32k : 480-32k].
- flush_i  input  1  invalidate the last-line buffer.
- mem_read_o  output  1  memory word read request.
- mem_addr_o  output  32  word byte address = {line_addr, beat[3:0], 2'b00}.
- mem_ack_i  input  1  memory word returned this cycle.
- mem_data_i  input  32  returned word, sampled when mem_ack_i is high.

Behaviour:
- Reset values (asynchronous, immediate):
  - state=IDLE; beat=0; buffer invalid; buffered address=0; line register=0.
  - l2_ack_o=0, mem_read_o=0, mem_addr_o=0, l2_data_o=0.
- State IDLE:
  - On l2_read_i=1, the address is latched into line_addr.
  - Buffer hit condition: ENABLE_LINE_BUFFER=1, buffer valid, l2_addr_i == buffered address, and flush_i=0. On a hit, go to ACK.
  - On a miss, clear beat to 0 and go to FETCH.
- State FETCH:
  - mem_read_o=1 and mem_addr_o={line_addr, beat, 2'b00}, both stable until mem_ack_i.
  - On mem_ack_i, mem_data_i is written into the word slot selected by beat, and beat increments.
  - The next beat's address is presented the following cycle.
  - mem_ack_i with beat=15 goes to ACK, loads buffered address=line_addr, and marks the buffer valid, unless a flush was seen during the fill.
  - mem_read_o drops in the ACK cycle.
- State ACK:
  - l2_ack_o=1 for exactly this cycle, provided l2_read_i is still high; then return to IDLE.
  - If l2_read_i dropped mid-fill (a protocol violation), the fill still completes and updates the buffer, but no ack is issued.
- Returning to IDLE after ACK guarantees the requester's deassert edge is observed before any new request is accepted. There is no back-to-back acceptance in the ACK cycle.
- l2_data_o is driven directly from the line register and holds its value until the next fill overwrites it. A buffer hit returns the unchanged register.
- Latency, measured from the l2_read_i rising edge to l2_ack_o:
  - Buffer hit: 2 cycles.
  - Miss: 1 + sum of the 16 beat latencies + 1, giving 18 cycles minimum with zero-wait memory.
- Flush rules:
  - flush_i in any state clears buffer valid next edge.
  - A flush during FETCH also blocks the valid set at fill completion, via a sticky flush_seen flag cleared on entering FETCH.
  - The in-flight line is still delivered and acked.
- Simultaneous events:
  - flush_i with a hitting request in IDLE: flush wins and the request is treated as a miss.
  - mem_ack_i outside FETCH is ignored.
- Beat counter is 4 bits and wraps 15→0. It is only meaningful in FETCH.
- Reset asserted mid-FETCH: abandon immediately and drop mem_read_o asynchronously. A memory ack arriving after reset release is ignored because state is IDLE.

Test Plan:
- Zero-wait memory returning word = byte address XOR 32'hA5A5_0000; request line 26'h0000041 → mem_addr_o steps 32'h0000_1040…32'h0000_107C. l2_ack_o rises 18 cycles after request for exactly 1 cycle, and l2_data_o[511:480] = 32'hA5A5_1040, l2_data_o[31:0] = 32'hA5A5_107C.
- Repeat request 26'h0000041 after ack → ack in 2 cycles, mem_read_o stays 0, data identical. With ENABLE_LINE_BUFFER=0 the same request takes 18 cycles.
- Memory with 3 wait cycles per beat on line 26'h3FFFFFF → mem_addr_o ends at 32'hFFFF_FFFC, ack at cycle 66, no extra mem_read_o.
- flush_i pulsed at beat 7 of a fill of 26'h0000010 → that line is still acked. The immediate repeat request misses and refetches 16 beats.
- reset asserted at beat 9 → mem_read_o=0 and l2_ack_o=0 immediately; a stray mem_ack_i next cycle causes no state change. A fresh request afterwards performs a full 16-beat fill.
- flush_i asserted in the same cycle as a request that would hit → full refetch and no 2-cycle ack.

Source files
------------

// File: rtl/l2_line_responder.sv
// L2 responder for L1 I-cache line fills: fetches a 64-byte line as sixteen
// 32-bit memory beats and answers repeat requests from a one-entry line buffer.
module l2_line_responder #(
    parameter int unsigned LINE_ADDR_WIDTH    = 26,
    parameter bit          ENABLE_LINE_BUFFER = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       l2_read_i,
    input  logic [LINE_ADDR_WIDTH-1:0] l2_addr_i,
    output logic                       l2_ack_o,
    output logic [511:0]               l2_data_o,
    input  logic                       flush_i,
    output logic                       mem_read_o,
    output logic [31:0]                mem_addr_o,
    input  logic                       mem_ack_i,
    input  logic [31:0]                mem_data_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ACK
    } state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [3:0]                 r_beat;
    logic [LINE_ADDR_WIDTH-1:0] r_line_addr;
    logic [LINE_ADDR_WIDTH-1:0] r_buf_addr;
    logic                       r_buf_valid;
    logic                       r_flush_seen;
    logic [511:0]               r_line;

    logic w_hit;
    logic w_start_fill;
    logic w_beat_ack;
    logic w_fill_done;

    // A flush arriving with the request wins over a buffer hit.
    assign w_hit = ENABLE_LINE_BUFFER && r_buf_valid &&
                   (l2_addr_i == r_buf_addr) && !flush_i;

    assign mem_addr_o = 32'({r_line_addr, r_beat, 2'b00});
    assign l2_data_o  = r_line;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        l2_ack_o     = 1'b0;
        mem_read_o   = 1'b0;
        w_start_fill = 1'b0;
        w_beat_ack   = 1'b0;
        w_fill_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (l2_read_i) begin
                    if (w_hit) begin
                        w_next = S_ACK;
                    end else begin
                        w_start_fill = 1'b1;
                        w_next       = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                mem_read_o = 1'b1;
                if (mem_ack_i) begin
                    w_beat_ack = 1'b1;
                    if (r_beat == 4'd15) begin
                        w_fill_done = 1'b1;
                        w_next      = S_ACK;
                    end
                end
            end
            S_ACK: begin
                // A requester that abandoned mid-fill gets no ack.
                l2_ack_o = l2_read_i;
                w_next   = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_beat       <= '0;
            r_line_addr  <= '0;
            r_buf_addr   <= '0;
            r_buf_valid  <= 1'b0;
            r_flush_seen <= 1'b0;
            r_line       <= '0;
        end else begin
            if (r_state == S_IDLE && l2_read_i) begin
                r_line_addr <= l2_addr_i;
            end

            if (w_start_fill) begin
                r_beat       <= '0;
                r_flush_seen <= 1'b0;
            end else begin
                if (r_state == S_FETCH && flush_i) begin
                    r_flush_seen <= 1'b1;
                end
                if (w_beat_ack) begin
                    r_beat <= r_beat + 4'd1;
                end
            end

            // Word k of the line lives at bits [511-32k -: 32].
            if (w_beat_ack) begin
                for (int unsigned k = 0; k < 16; k++) begin
                    if (r_beat == 4'(k)) begin
                        r_line[511-32*k -: 32] <= mem_data_i;
                    end
                end
            end

            if (w_fill_done) begin
                r_buf_addr <= r_line_addr;
            end

            if (flush_i) begin
                r_buf_valid <= 1'b0;
            end else if (w_fill_done && !r_flush_seen) begin
                r_buf_valid <= ENABLE_LINE_BUFFER;
            end
        end
    end

endmodule

// File: tb/tb_l2_line_responder.sv
// Self-checking bench for l2_line_responder: directed scenarios plus randomized
// requests scored against a line-level model of the last-line buffer.
module tb_l2_line_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         l2_read_i;
    logic [25:0]  l2_addr_i;
    logic         flush_i;
    logic         l2_ack_o;
    logic [511:0] l2_data_o;
    logic         mem_read_o;
    logic [31:0]  mem_addr_o;
    logic         mem_ack_i;
    logic [31:0]  mem_data_i;

    logic         read_b;
    logic [25:0]  addr_b;
    logic         ack_b;
    logic [511:0] data_b;
    logic         mread_b;
    logic [31:0]  maddr_b;
    logic         flush_b;

    int unsigned  wait_cfg = 0;
    int unsigned  wcnt = 0;
    logic         stray_ack;
    logic [31:0]  key;

    int checks = 0;
    int errors = 0;

    logic         model_valid;
    logic [25:0]  model_addr;
    logic [511:0] model_line;

    l2_line_responder #(
        .LINE_ADDR_WIDTH(26),
        .ENABLE_LINE_BUFFER(1'b1)
    ) dut (
        .clk(clk), .reset(reset),
        .l2_read_i(l2_read_i), .l2_addr_i(l2_addr_i),
        .l2_ack_o(l2_ack_o), .l2_data_o(l2_data_o),
        .flush_i(flush_i),
        .mem_read_o(mem_read_o), .mem_addr_o(mem_addr_o),
        .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i)
    );

    l2_line_responder #(
        .LINE_ADDR_WIDTH(26),
        .ENABLE_LINE_BUFFER(1'b0)
    ) dut_nobuf (
        .clk(clk), .reset(reset),
        .l2_read_i(read_b), .l2_addr_i(addr_b),
        .l2_ack_o(ack_b), .l2_data_o(data_b),
        .flush_i(flush_b),
        .mem_read_o(mread_b), .mem_addr_o(maddr_b),
        .mem_ack_i(mread_b), .mem_data_i(maddr_b ^ 32'hA5A5_0000)
    );

    // Memory: each beat answers after wait_cfg idle cycles.
    assign mem_ack_i  = (mem_read_o && wcnt == wait_cfg) || stray_ack;
    assign mem_data_i = mem_addr_o ^ key;
    always @(posedge clk) begin
        if (!mem_read_o || mem_ack_i) wcnt <= 0;
        else                          wcnt <= wcnt + 1;
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] line_of(input logic [25:0] a, input logic [31:0] k);
        logic [511:0] l;
        l = '0;
        for (int w = 0; w < 16; w++) begin
            l[511-32*w -: 32] = {a, 4'(w), 2'b00} ^ k;
        end
        return l;
    endfunction

    // Issue one request from one cycle after a rising edge and score it.
    task automatic do_req(input logic [25:0] a, input int unsigned w, input bit fr,
                          input int fb, input logic [31:0] k);
        bit           hit, got, addr_ok, fl_mid;
        int           n, reads, beats, exp_lat, exp_reads;
        logic [511:0] exp_line;
        hit       = model_valid && (a == model_addr) && !fr;
        exp_line  = hit ? model_line : line_of(a, k);
        exp_lat   = hit ? 2 : 2 + 16 * (int'(w) + 1);
        exp_reads = hit ? 0 : 16 * (int'(w) + 1);
        key       = k;
        wait_cfg  = w;
        l2_addr_i = a;
        l2_read_i = 1'b1;
        flush_i   = fr;
        n = 0; reads = 0; beats = 0; got = 1'b0; addr_ok = 1'b1; fl_mid = 1'b0;
        while (!got && n < 400) begin
            @(posedge clk);
            n++;
            #1 flush_i = 1'b0;
            @(negedge clk);
            if (l2_ack_o) begin
                got = 1'b1;
            end else begin
                if (mem_read_o) reads++;
                if (mem_ack_i) begin
                    if (mem_addr_o !== {a, 4'(beats), 2'b00}) addr_ok = 1'b0;
                    beats++;
                    if (beats == fb) begin
                        flush_i = 1'b1;
                        fl_mid  = 1'b1;
                    end
                end
            end
        end
        chk("ack_seen", 512'(got), 512'(1));
        chk("latency", 512'(n + 1), 512'(exp_lat));
        chk("mem_reads", 512'(reads), 512'(exp_reads));
        chk("beats", 512'(beats), 512'(hit ? 0 : 16));
        chk("beat_addr", 512'(addr_ok), 512'(1));
        chk("line_data", l2_data_o, exp_line);
        @(posedge clk);
        #1 l2_read_i = 1'b0;
        chk("ack_pulse", 512'(l2_ack_o), 512'(0));
        chk("rd_after", 512'(mem_read_o), 512'(0));
        if (!hit) begin
            model_line  = exp_line;
            model_addr  = a;
            model_valid = !fl_mid;
        end
        @(posedge clk);
        #1;
    endtask

    logic [25:0] ra;
    int unsigned rw, sel;
    bit          rfr;
    int          rfb, n, beats;
    bit          got;

    initial begin
        reset = 1'b1; l2_read_i = 1'b0; l2_addr_i = '0; flush_i = 1'b0;
        read_b = 1'b0; addr_b = '0; flush_b = 1'b0;
        stray_ack = 1'b0; key = 32'hA5A5_0000;
        model_valid = 1'b0; model_addr = '0; model_line = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", 512'(l2_ack_o), 512'(0));
        chk("rst_mread", 512'(mem_read_o), 512'(0));
        chk("rst_maddr", 512'(mem_addr_o), 512'(0));
        chk("rst_data", l2_data_o, '0);
        chk("rst_b_mread", 512'(mread_b), 512'(0));
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;

        // Zero-wait miss, then buffered repeat.
        do_req(26'h0000041, 0, 1'b0, -1, 32'hA5A5_0000);
        chk("word0", 512'(l2_data_o[511:480]), 512'(32'hA5A5_1040));
        chk("word15", 512'(l2_data_o[31:0]), 512'(32'hA5A5_107C));
        do_req(26'h0000041, 0, 1'b0, -1, 32'h1234_5678);
        chk("hit_word0", 512'(l2_data_o[511:480]), 512'(32'hA5A5_1040));

        // Buffer disabled: every request is a full fill.
        for (int r = 0; r < 2; r++) begin
            addr_b = 26'h0000041; read_b = 1'b1; n = 0; got = 1'b0;
            while (!got && n < 100) begin
                @(posedge clk);
                n++;
                @(negedge clk);
                if (ack_b) got = 1'b1;
            end
            chk("nobuf_latency", 512'(n + 1), 512'(18));
            @(posedge clk);
            #1 read_b = 1'b0;
            @(posedge clk);
            #1;
        end
        chk("nobuf_word0", 512'(data_b[511:480]), 512'(32'hA5A5_1040));

        // Top line address with three wait cycles per beat.
        do_req(26'h3FFFFFF, 3, 1'b0, -1, $urandom);

        // Flush mid-fill: line delivered, repeat refetches, then buffered again.
        do_req(26'h0000010, 0, 1'b0, 7, $urandom);
        do_req(26'h0000010, 0, 1'b0, -1, $urandom);
        // Flush together with a hitting request forces a refetch.
        do_req(26'h0000010, 0, 1'b1, -1, $urandom);
        do_req(26'h0000010, 1, 1'b0, -1, $urandom);

        // Reset in the middle of a fill.
        key = $urandom; wait_cfg = 0;
        l2_addr_i = 26'h0000123; l2_read_i = 1'b1; beats = 0; n = 0;
        while (beats < 9 && n < 100) begin
            @(negedge clk);
            n++;
            if (mem_ack_i) beats++;
        end
        chk("rst_reach_beat", 512'(beats), 512'(9));
        @(negedge clk);
        reset = 1'b1; l2_read_i = 1'b0;
        #1;
        chk("midrst_mread", 512'(mem_read_o), 512'(0));
        chk("midrst_ack", 512'(l2_ack_o), 512'(0));
        @(negedge clk);
        reset = 1'b0; stray_ack = 1'b1;
        @(posedge clk);
        #1 stray_ack = 1'b0;
        chk("stray_mread", 512'(mem_read_o), 512'(0));
        chk("stray_ack", 512'(l2_ack_o), 512'(0));
        chk("stray_maddr", 512'(mem_addr_o), 512'(0));
        chk("stray_data", l2_data_o, '0);
        model_valid = 1'b0; model_addr = '0; model_line = '0;
        @(posedge clk);
        #1;
        do_req(26'h0000123, 0, 1'b0, -1, $urandom);

        // Randomized mix of repeats, new lines, wait states and flushes.
        for (int i = 0; i < 16; i++) begin
            sel = $urandom_range(0, 3);
            ra  = (sel == 0) ? 26'h0000041 : (sel == 1) ? 26'h0000123 : 26'($urandom);
            rw  = $urandom_range(0, 2);
            rfr = ($urandom_range(0, 5) == 0);
            rfb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 14)) : -1;
            do_req(ra, rw, rfr, rfb, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
